// File: rtl/uart_pkg.sv
// Shared UART constants: FIFO sizing, status-register bit positions and the
// pointer-width helper used by the receive buffer.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_BYTE_W     = 8;

  // Bit positions in the UART status register
  localparam int UART_STAT_RX_VALID = 0;
  localparam int UART_STAT_RX_AFULL = 1;
  localparam int UART_STAT_TX_READY = 2;

  function automatic int uart_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the UART decoder.
// Occupancy is tracked in a dedicated counter; full/empty derive from it.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_FIFO_DEPTH,
  parameter int WIDTH       = UART_BYTE_W,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int PW = uart_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Ready and valid depend only on registered occupancy, never on the
  // opposite handshake, so no combinational path crosses the buffer.
  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Array contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= in_data;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the memory-mapped UART decoder. Absorbs bursts of serial input so that bytes are held while the CPU is busy, instead of being lost. It exposes a ready/valid stream on both sides, plus fill-level status for the UART status register read path.

## Interface
Parameters:
- DEPTH, 16: number of byte entries; must be a power of two, at least 2.
- WIDTH, 8: data width in bits.
- AFULL_LEVEL, 12: `almost_full` asserts when `count` ≥ this value; range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  byte from the UART receiver (DataOut).
- in_valid  in  1  receiver holds a byte (DataOutValid).
- in_ready  out  1  FIFO accepts the byte this cycle (drives DataOutReady).
- out_data  out  WIDTH  head byte, presented to the decoder read path.
- out_valid  out  1  FIFO non-empty; feeds the decoder's receive-valid status bit.
- out_ready  in  1  decoder consumes the head byte this cycle (load from the UART receive-data address).
- flush  in  1  synchronous clear; pulsed by a CPU store to the control address.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  `count` ≥ AFULL_LEVEL.

## Operation
- Storage is a circular array of DEPTH entries, addressed by a write pointer and a read pointer. Each pointer is $clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
- Occupancy is held in a separate `count` register; full and empty are derived from `count`, not from pointer comparison.
- `push` = in_valid & in_ready: write in_data at wptr, then wptr+1.
- `pop` = out_valid & out_ready: rptr+1.
- `count` next value:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- `in_ready` = (count != DEPTH). When full, a simultaneous pop does not enable a push in the same cycle (no combinational ready-from-pop path).
- `out_valid` = (count != 0). `out_data` = mem[rptr], combinational read of the registered array (first-word fall-through).
- When empty, `out_ready` is ignored and no pop occurs.
- `flush`: on the next edge, wptr, rptr and count return to 0. Flush overrides any push or pop in the same cycle; a byte presented that cycle is discarded. `in_ready` stays combinational on `count`, so it may be high during the flush cycle.
- Array contents are not reset; only pointers and `count` are.
- `almost_full` is derived combinationally from `count`.

## Timing
- Reset values: wptr=0, rptr=0, count=0. Outputs: in_ready=1, out_valid=0, almost_full=0, out_data=don't-care.
- Reset is asserted asynchronously mid-operation: all state clears immediately and all queued bytes are lost.
- Latency: a byte pushed at edge N gives out_valid=1 and out_data=that byte in the cycle after edge N; effectively 1 cycle.
- Throughput: one push and one pop per cycle, sustained, whenever 0 < count < DEPTH.
- Full boundary: with count=DEPTH, in_ready=0. A pop at edge N makes in_ready=1 after edge N.
- Empty boundary: with count=0 and push at edge N, a pop is possible earliest at edge N+1.
- No combinational path from in_valid or out_ready to any output.

## Structure
- Shared package `uart_pkg`: UART_FIFO_DEPTH (16), UART_BYTE_W (8), the UART status-register bit positions (rx_valid, rx_afull, tx_ready), and the pointer-width function.
- No sub-module: the array, pointers and counter fit in a single module.
- Instantiated in the CPU top between UART and the UART decoder. The decoder's receive-data load drives `out_ready` for one cycle.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on consecutive cycles with out_ready=0 → count=3; out_data=0x41 one cycle after the first push.
- Pop three times → out_data goes 0x41, 0x42, 0x43; out_valid=0 and count=0 after the third pop.
- Fill to 16 with 0x00..0x0F → in_ready=0 and almost_full=1 (from count=12). A 17th push of 0xFF is not accepted. One pop returns 0x00 and in_ready=1 the next cycle.
- Steady state at count=5: simultaneous push/pop for 40 cycles → count stays 5, pointers wrap past 15, and output order equals input order.
- At count=7, assert flush together with a push of 0x55 → next cycle count=0, out_valid=0. Byte 0x55 is never output, and the next pushed byte 0x66 is the head.
- At count=9, pulse rst asynchronously between edges → out_valid=0, count=0, in_ready=1 immediately, without waiting for a clock edge.
